// File: rtl/data_bus_controller.sv
// Load/store bus controller: aligns core requests onto a 32-bit word bus with byte enables.
// Optional watchdog enabled by defining DATA_BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module data_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        read_enable_i,
  input  logic        write_enable_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic [2:0]  data_format_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_error_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [31:0] bus_address_o,
  output logic        bus_write_o,
  output logic [3:0]  bus_byte_enable_o,
  output logic [31:0] bus_write_data_o,
  input  logic        bus_rsp_valid_i,
  input  logic [31:0] bus_rsp_data_i
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

  state_e      state_q, state_d;
  logic        bus_valid_q, bus_valid_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic        bus_write_q, bus_write_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [2:0]  fmt_q, fmt_d;
  logic [1:0]  off_q, off_d;

  logic        req_any, size_b, size_h, size_w, misalign, accept;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, rsp_lane, rsp_ext;

  // Codes 011, 110 and 111 fall into the word bucket via data_format_i[1].
  assign size_b   = (data_format_i[1:0] == 2'b00);
  assign size_h   = (data_format_i[1:0] == 2'b01);
  assign size_w   = data_format_i[1];
  assign req_any  = read_enable_i | write_enable_i;
  assign misalign = (size_h & address_i[0]) | (size_w & (|address_i[1:0]));
  assign accept   = (state_q == StIdle) & req_any & ~misalign;

  assign misaligned_o = (state_q == StIdle) & req_any & misalign;
  assign stall_o      = accept | (state_q == StReq) | (state_q == StRsp);

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = write_data_i;
    if (size_b) begin
      be_new    = 4'b0001 << address_i[1:0];
      wdata_new = {4{write_data_i[7:0]}};
    end else if (size_h) begin
      be_new    = 4'b0011 << address_i[1:0];
      wdata_new = {2{write_data_i[15:0]}};
    end
  end

  always_comb begin
    rsp_lane = bus_rsp_data_i >> {off_q, 3'b000};
    case (fmt_q)
      3'b000:  rsp_ext = {{24{rsp_lane[7]}}, rsp_lane[7:0]};
      3'b100:  rsp_ext = {24'h0, rsp_lane[7:0]};
      3'b001:  rsp_ext = {{16{rsp_lane[15]}}, rsp_lane[15:0]};
      3'b101:  rsp_ext = {16'h0, rsp_lane[15:0]};
      default: rsp_ext = rsp_lane;
    endcase
  end

`ifdef DATA_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_error_q, bus_error_d;
  logic            phase_done;

  assign phase_done = ((state_q == StReq) & bus_ready_i) | ((state_q == StRsp) & bus_rsp_valid_i);
`endif

  always_comb begin
    state_d       = state_q;
    bus_valid_d   = bus_valid_q;
    bus_address_d = bus_address_q;
    bus_write_d   = bus_write_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    read_data_d   = read_data_q;
    fmt_d         = fmt_q;
    off_d         = off_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d       = StReq;
          bus_valid_d   = 1'b1;
          bus_address_d = {address_i[31:2], 2'b00};
          bus_write_d   = write_enable_i;
          bus_be_d      = be_new;
          bus_wdata_d   = wdata_new;
          fmt_d         = data_format_i;
          off_d         = address_i[1:0];
        end
      end
      StReq: begin
        if (bus_ready_i) begin
          bus_valid_d = 1'b0;
          state_d     = bus_write_q ? StDone : StRsp;
        end
      end
      StRsp: begin
        if (bus_rsp_valid_i) begin
          read_data_d = rsp_ext;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef DATA_BUS_TIMEOUT_EN
    cnt_d       = '0;
    bus_error_d = 1'b0;
    if ((state_q == StReq) || (state_q == StRsp)) begin
      cnt_d = cnt_q + CntW'(1);
      if (!phase_done && (cnt_q == CntLast)) begin
        state_d     = StDone;
        bus_valid_d = 1'b0;
        read_data_d = '0;
        bus_error_d = 1'b1;
        cnt_d       = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      bus_valid_q   <= 1'b0;
      bus_address_q <= '0;
      bus_write_q   <= 1'b0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      read_data_q   <= '0;
      fmt_q         <= '0;
      off_q         <= '0;
    end else begin
      state_q       <= state_d;
      bus_valid_q   <= bus_valid_d;
      bus_address_q <= bus_address_d;
      bus_write_q   <= bus_write_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      read_data_q   <= read_data_d;
      fmt_q         <= fmt_d;
      off_q         <= off_d;
    end
  end

`ifdef DATA_BUS_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error_o = bus_error_q;
`else
  // Without the watchdog the limit has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus_error_o        = 1'b0;
`endif

  assign read_data_o       = read_data_q;
  assign bus_valid_o       = bus_valid_q;
  assign bus_address_o     = bus_address_q;
  assign bus_write_o       = bus_write_q;
  assign bus_byte_enable_o = bus_be_q;
  assign bus_write_data_o  = bus_wdata_q;

endmodule

// File: tb/tb_data_bus_controller.sv
// Directed bench for data_bus_controller with a bus-request and load-result scoreboard.
module tb_data_bus_controller;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        read_enable_i, write_enable_i;
  logic [31:0] address_i, write_data_i;
  logic [2:0]  data_format_i;
  logic [31:0] read_data_o;
  logic        stall_o, misaligned_o, bus_error_o, bus_valid_o, bus_ready_i;
  logic [31:0] bus_address_o;
  logic        bus_write_o;
  logic [3:0]  bus_byte_enable_o;
  logic [31:0] bus_write_data_o;
  logic        bus_rsp_valid_i;
  logic [31:0] bus_rsp_data_i;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        wr;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];

  always #5 clk_i = ~clk_i;

  data_bus_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .read_enable_i    (read_enable_i),
    .write_enable_i   (write_enable_i),
    .address_i        (address_i),
    .write_data_i     (write_data_i),
    .data_format_i    (data_format_i),
    .read_data_o      (read_data_o),
    .stall_o          (stall_o),
    .misaligned_o     (misaligned_o),
    .bus_error_o      (bus_error_o),
    .bus_valid_o      (bus_valid_o),
    .bus_ready_i      (bus_ready_i),
    .bus_address_o    (bus_address_o),
    .bus_write_o      (bus_write_o),
    .bus_byte_enable_o(bus_byte_enable_o),
    .bus_write_data_o (bus_write_data_o),
    .bus_rsp_valid_i  (bus_rsp_valid_i),
    .bus_rsp_data_i   (bus_rsp_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One core request; the bus side answers ready after rdy_delay wait cycles, response at once.
  task automatic do_txn(input string tag, input logic re, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] fmt,
                        input logic [31:0] rsp, input int rdy_delay, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd, input int exp_stall);
    req_t r;
    int   stalls;
    int   waited;
    bit   done;
    bit   in_rsp;
    r.addr = {addr[31:2], 2'b00};
    r.be   = exp_be;
    r.wd   = exp_wd;
    r.wr   = we;
    req_q.push_back(r);
    if (!we) rd_q.push_back(exp_rd);
    stalls = 0;
    waited = 0;
    done   = 1'b0;
    @(posedge clk_i); #1;
    read_enable_i   = re;
    write_enable_i  = we;
    address_i       = addr;
    write_data_i    = wdata;
    data_format_i   = fmt;
    bus_ready_i     = 1'b0;
    bus_rsp_valid_i = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      else begin
        done = 1'b1;
        chk({tag, " bus_error"}, bus_error_o, 0);
        if (!we && rd_q.size() > 0) chk({tag, " read_data"}, read_data_o, rd_q.pop_front());
      end
      if (bus_valid_o) begin
        if (req_q.size() == 0) chk({tag, " unexpected bus_valid"}, bus_valid_o, 0);
        else begin
          chk({tag, " bus_address"}, bus_address_o, req_q[0].addr);
          chk({tag, " byte_enable"}, bus_byte_enable_o, req_q[0].be);
          chk({tag, " bus_write_data"}, bus_write_data_o, req_q[0].wd);
          chk({tag, " bus_write"}, bus_write_o, req_q[0].wr);
          if (bus_ready_i) void'(req_q.pop_front());
          else waited++;
        end
      end
      if (!done) begin
        @(posedge clk_i); #1;
        in_rsp          = stall_o && !bus_valid_o;
        bus_ready_i     = bus_valid_o && (waited >= rdy_delay);
        bus_rsp_valid_i = in_rsp;
        bus_rsp_data_i  = in_rsp ? rsp : $urandom;
        // Core-side inputs wander while the transaction is in flight.
        read_enable_i   = 1'b0;
        write_enable_i  = 1'b0;
        address_i       = $urandom;
        write_data_i    = $urandom;
        data_format_i   = 3'($urandom);
      end
    end
    if (!done) chk({tag, " completion"}, stall_o, 0);
    chk({tag, " stall cycles"}, stalls, exp_stall);
    chk({tag, " request consumed"}, req_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni          = 1'b0;
    read_enable_i   = 1'b0;
    write_enable_i  = 1'b0;
    address_i       = '0;
    write_data_i    = '0;
    data_format_i   = '0;
    bus_ready_i     = 1'b0;
    bus_rsp_valid_i = 1'b0;
    bus_rsp_data_i  = '0;
    #12;
    chk("reset read_data", read_data_o, 0);
    chk("reset stall", stall_o, 0);
    chk("reset bus_valid", bus_valid_o, 0);
    chk("reset byte_enable", bus_byte_enable_o, 0);
    chk("reset bus_address", bus_address_o, 0);
    chk("reset misaligned", misaligned_o, 0);
    chk("reset bus_error", bus_error_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    do_txn("LB 0x103", 1, 0, 32'h103, 32'h0, 3'b000, 32'h80FF_1234, 0,
           4'b1000, 32'h0, 32'hFFFF_FF80, 3);
    do_txn("SH 0x202", 0, 1, 32'h202, 32'h0000_BEEF, 3'b001, 32'h0, 0,
           4'b1100, 32'hBEEF_BEEF, 32'h0, 2);
    chk("read_data held over store", read_data_o, 32'hFFFF_FF80);
    do_txn("LHU 0x0 slow", 1, 0, 32'h0, 32'h0, 3'b101, 32'h1234_ABCD, 5,
           4'b0011, 32'h0, 32'h0000_ABCD, 8);
    do_txn("LH 0x2", 1, 0, 32'h2, 32'h0, 3'b001, 32'h8001_0000, 0,
           4'b1100, 32'h0, 32'hFFFF_8001, 3);
    do_txn("LBU 0x1", 1, 0, 32'h1, 32'h0, 3'b100, 32'h0000_F000, 1,
           4'b0010, 32'h0, 32'h0000_00F0, 4);
    do_txn("LW 0x40", 1, 0, 32'h40, 32'h0, 3'b010, 32'hDEAD_BEEF, 2,
           4'b1111, 32'h0, 32'hDEAD_BEEF, 5);
    do_txn("SB 0x301", 0, 1, 32'h301, 32'h1234_5678, 3'b000, 32'h0, 0,
           4'b0010, 32'h7878_7878, 32'h0, 2);
    chk("read_data held over SB", read_data_o, 32'hDEAD_BEEF);
    do_txn("SW 0x404", 0, 1, 32'h404, 32'hCAFE_F00D, 3'b010, 32'h0, 3,
           4'b1111, 32'hCAFE_F00D, 32'h0, 5);
    do_txn("RE+WE store", 1, 1, 32'h10, 32'h1122_3344, 3'b010, 32'h0, 0,
           4'b1111, 32'h1122_3344, 32'h0, 2);
    do_txn("fmt 011 as W", 1, 0, 32'h20, 32'h0, 3'b011, 32'h5566_7788, 0,
           4'b1111, 32'h0, 32'h5566_7788, 3);
    do_txn("LB 0x2 positive", 1, 0, 32'h2, 32'h0, 3'b000, 32'h007F_0000, 0,
           4'b0100, 32'h0, 32'h0000_007F, 3);
    do_txn("fmt 110 as W", 1, 0, 32'h8, 32'h0, 3'b110, 32'h8000_0001, 0,
           4'b1111, 32'h0, 32'h8000_0001, 3);

    // Misaligned word load and half store: pulse only, no bus activity.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      read_enable_i  = (k == 0);
      write_enable_i = (k == 1);
      address_i      = (k == 0) ? 32'h101 : 32'h203;
      data_format_i  = (k == 0) ? 3'b010 : 3'b001;
      write_data_i   = 32'hA5A5_A5A5;
      @(negedge clk_i);
      chk("misaligned pulse", misaligned_o, 1);
      chk("misaligned stall", stall_o, 0);
      chk("misaligned bus_valid", bus_valid_o, 0);
      @(posedge clk_i); #1;
      read_enable_i  = 1'b0;
      write_enable_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk_i);
        chk("misaligned pulse cleared", misaligned_o, 0);
        chk("misaligned no bus_valid", bus_valid_o, 0);
      end
    end
    chk("read_data after misaligned", read_data_o, 32'h8000_0001);

    // Reset while waiting for a load response.
    @(posedge clk_i); #1;
    read_enable_i = 1'b1;
    address_i     = 32'h4;
    data_format_i = 3'b010;
    @(posedge clk_i); #1;
    read_enable_i = 1'b0;
    bus_ready_i   = 1'b1;
    @(negedge clk_i);
    chk("rst-mid bus_valid in REQ", bus_valid_o, 1);
    @(posedge clk_i); #1;
    bus_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rst-mid stall in RSP", stall_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst-mid stall", stall_o, 0);
    chk("rst-mid bus_valid", bus_valid_o, 0);
    chk("rst-mid read_data", read_data_o, 0);
    chk("rst-mid byte_enable", bus_byte_enable_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i); #1;
      bus_rsp_valid_i = 1'b1;
      bus_rsp_data_i  = 32'h1234_5678;
      @(negedge clk_i);
      chk("stray rsp stall", stall_o, 0);
      chk("stray rsp read_data", read_data_o, 0);
    end
    @(posedge clk_i); #1;
    bus_rsp_valid_i = 1'b0;
    do_txn("LW after reset", 1, 0, 32'h44, 32'h0, 3'b010, 32'h0BAD_F00D, 0,
           4'b1111, 32'h0, 32'h0BAD_F00D, 3);

`ifdef DATA_BUS_TIMEOUT_EN
    begin
      int errc;
      errc = -1;
      @(posedge clk_i); #1;
      read_enable_i = 1'b1;
      address_i     = 32'h30;
      data_format_i = 3'b010;
      bus_ready_i   = 1'b0;
      for (int cyc = 0; cyc < 40 && errc < 0; cyc++) begin
        @(negedge clk_i);
        if (bus_error_o) begin
          errc = cyc;
          chk("timeout stall", stall_o, 0);
          chk("timeout read_data", read_data_o, 0);
          chk("timeout bus_valid", bus_valid_o, 0);
        end
        @(posedge clk_i); #1;
        read_enable_i = 1'b0;
      end
      chk("timeout cycle", errc, 9);
      @(negedge clk_i);
      chk("timeout pulse width", bus_error_o, 0);
    end
`endif

    chk("request queue drained", req_q.size(), 0);
    chk("read queue drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
